// File: rtl/request_receiver.sv
// request_receiver: assembles a code/address byte pair from UART_RX, validates it,
// enforces an inter-byte timeout and issues one registered request when downstream is free.
module request_receiver #(
   parameter int         TIMEOUT_CYCLES = 5_000_000,
   parameter logic [7:0] MAX_CODE       = 8'h06,
   parameter logic [7:0] MAX_ADDRESS    = 8'd31
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       busy,
   output logic       request_valid,
   output logic [7:0] request_code,
   output logic [7:0] sensor_address,
   output logic       request_error,
   output logic [1:0] error_type
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   typedef enum logic [1:0] {WAIT_CODE, WAIT_ADDR, ISSUE} state_t;
   state_t state, state_n;
   logic [CW-1:0] count, count_n;
   logic [7:0] code_q, code_n, addr_q, addr_n;
   logic valid_n, error_n;
   logic [1:0] etype_n;

   always_comb begin
      state_n = state;
      count_n = count;
      code_n  = code_q;
      addr_n  = addr_q;
      valid_n = 1'b0;
      error_n = 1'b0;
      etype_n = error_type;
      case (state)
         WAIT_CODE:
            if (rx_done) begin
               code_n  = rx_data;
               count_n = '0;
               state_n = WAIT_ADDR;
            end
         WAIT_ADDR:
            // an arriving byte always beats the timeout terminal count
            if (rx_done) begin
               addr_n = rx_data;
               if (code_q > MAX_CODE) begin
                  error_n = 1'b1;
                  etype_n = 2'd1;
                  state_n = WAIT_CODE;
               end else if (rx_data > MAX_ADDRESS) begin
                  error_n = 1'b1;
                  etype_n = 2'd2;
                  state_n = WAIT_CODE;
               end else begin
                  state_n = ISSUE;
               end
            end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
               error_n = 1'b1;
               etype_n = 2'd3;
               state_n = WAIT_CODE;
            end else begin
               count_n = count + 1'b1;
            end
         ISSUE: begin
            if (!busy) begin
               valid_n = 1'b1;
               state_n = WAIT_CODE;
            end
            if (rx_done) begin
               error_n = 1'b1;
               etype_n = 2'd0;
            end
         end
         default: state_n = WAIT_CODE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= WAIT_CODE;
         count          <= '0;
         code_q         <= '0;
         addr_q         <= '0;
         request_valid  <= 1'b0;
         request_error  <= 1'b0;
         request_code   <= '0;
         sensor_address <= '0;
         error_type     <= '0;
      end else begin
         state         <= state_n;
         count         <= count_n;
         code_q        <= code_n;
         addr_q        <= addr_n;
         request_valid <= valid_n;
         request_error <= error_n;
         error_type    <= etype_n;
         if (valid_n) begin
            request_code   <= code_q;
            sensor_address <= addr_q;
         end
      end
   end
endmodule
